cond_flag_unit: RTL and testbench

- Execute-stage consumer of the ALU's result flags, sitting directly downstream of the ALU.
- Holds the architectural NZCV flag register and evaluates each instruction's 4-bit condition field against the current flags.
- Gates register-write, memory-write and PC-select controls, and registers them into the E/M pipeline boundary.
- Keeps a saturating count of squashed (condition-failed) instructions for debug.

---
 rtl/cond_flag_unit_pkg.sv | 29 ++
 rtl/cond_flag_unit_cond_check.sv | 43 ++++
 rtl/cond_flag_unit.sv | 108 ++++++++++
 tb/tb_cond_flag_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/cond_flag_unit_pkg.sv
// Shared definitions for the condition/flag unit: condition-code encoding and
// NZCV bit positions within the flag vector.
package cond_flag_unit_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE,
        COND_NV = 4'hF
    } cond_code_e;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_flag_unit_cond_check.sv
// Pure combinational condition evaluator: does a 4-bit condition code pass
// against a given NZCV flag vector. Shared with branch resolution logic.
module cond_check
    import cond_flag_unit_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic z, n, c, v;

    assign z = flags[FLAG_Z];
    assign n = flags[FLAG_N];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    // NOTE: every output of an always_comb gets a default before the case,
    // so no path through the block can leave it unassigned and infer a latch.
    always_comb begin
        pass = 1'b0;
        case (cond_code_e'(cond))
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_flag_unit.sv
// Execute-stage condition unit: owns the NZCV flag register, gates the
// write/branch controls by the instruction condition and registers them into E/M.
module cond_flag_unit
    import cond_flag_unit_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             valid_e,
    input  logic [3:0]       cond_e,
    input  logic [1:0]       flag_write_e,
    input  logic [3:0]       alu_flags,
    input  logic             reg_write_e,
    input  logic             mem_write_e,
    input  logic             pc_src_e,
    output logic             cond_ex,
    output logic [3:0]       flags_q,
    output logic             reg_write_m,
    output logic             mem_write_m,
    output logic             pc_src_m,
    output logic             illegal_cond_m,
    output logic [CNT_W-1:0] squash_cnt
);

    logic             pass;
    logic [3:0]       flags_d;
    logic             reg_write_q, reg_write_d;
    logic             mem_write_q, mem_write_d;
    logic             pc_src_q, pc_src_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] squash_cnt_q, squash_cnt_d;

    // Evaluated on the registered flags only: results from the instruction
    // currently in the ALU are not forwarded.
    cond_check u_cond_check (
        .cond  (cond_e),
        .flags (flags_q),
        .pass  (pass)
    );

    assign cond_ex = valid_e & pass;

    always_comb begin
        flags_d      = flags_q;
        reg_write_d  = reg_write_q;
        mem_write_d  = mem_write_q;
        pc_src_d     = pc_src_q;
        illegal_d    = illegal_q;
        squash_cnt_d = squash_cnt_q;

        if (flush) begin
            reg_write_d = 1'b0;
            mem_write_d = 1'b0;
            pc_src_d    = 1'b0;
            illegal_d   = 1'b0;
        end else if (!stall) begin
            reg_write_d = reg_write_e & cond_ex;
            mem_write_d = mem_write_e & cond_ex;
            pc_src_d    = pc_src_e & cond_ex;
            illegal_d   = valid_e & (cond_e == COND_NV);

            if (cond_ex) begin
                if (flag_write_e[1]) begin
                    flags_d[FLAG_Z] = alu_flags[FLAG_Z];
                    flags_d[FLAG_N] = alu_flags[FLAG_N];
                end
                if (flag_write_e[0]) begin
                    flags_d[FLAG_C] = alu_flags[FLAG_C];
                    flags_d[FLAG_V] = alu_flags[FLAG_V];
                end
            end

            if (valid_e && !cond_ex && (squash_cnt_q != {CNT_W{1'b1}})) begin
                squash_cnt_d = squash_cnt_q + CNT_W'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q      <= 4'b0000;
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            pc_src_q     <= 1'b0;
            illegal_q    <= 1'b0;
            squash_cnt_q <= '0;
        end else begin
            flags_q      <= flags_d;
            reg_write_q  <= reg_write_d;
            mem_write_q  <= mem_write_d;
            pc_src_q     <= pc_src_d;
            illegal_q    <= illegal_d;
            squash_cnt_q <= squash_cnt_d;
        end
    end

    assign reg_write_m    = reg_write_q;
    assign mem_write_m    = mem_write_q;
    assign pc_src_m       = pc_src_q;
    assign illegal_cond_m = illegal_q;
    assign squash_cnt     = squash_cnt_q;

endmodule

// File: tb/tb_cond_flag_unit.sv
// Self-checking bench for cond_flag_unit: directed vector table, randomized
// traffic against a behavioural model, and squash-counter saturation.
module tb_cond_flag_unit;

    localparam int CNT_W   = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic             stall;
    logic             flush;
    logic             valid_e;
    logic [3:0]       cond_e;
    logic [1:0]       flag_write_e;
    logic [3:0]       alu_flags;
    logic             reg_write_e;
    logic             mem_write_e;
    logic             pc_src_e;
    logic             cond_ex;
    logic [3:0]       flags_q;
    logic             reg_write_m;
    logic             mem_write_m;
    logic             pc_src_m;
    logic             illegal_cond_m;
    logic [CNT_W-1:0] squash_cnt;

    cond_flag_unit #(.CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .flush          (flush),
        .valid_e        (valid_e),
        .cond_e         (cond_e),
        .flag_write_e   (flag_write_e),
        .alu_flags      (alu_flags),
        .reg_write_e    (reg_write_e),
        .mem_write_e    (mem_write_e),
        .pc_src_e       (pc_src_e),
        .cond_ex        (cond_ex),
        .flags_q        (flags_q),
        .reg_write_m    (reg_write_m),
        .mem_write_m    (mem_write_m),
        .pc_src_m       (pc_src_m),
        .illegal_cond_m (illegal_cond_m),
        .squash_cnt     (squash_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst, stall, flush, valid;
        logic [3:0]  cond;
        logic [1:0]  fw;
        logic [3:0]  alu;
        logic        rw, mw, pc;
        logic        e_ce;
        logic [3:0]  e_flags;
        logic        e_rw, e_mw, e_pc, e_ill;
        logic [15:0] e_cnt;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [3:0] m_flags;
    logic       m_rw, m_mw, m_pc, m_ill;
    int         m_cnt;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Conditions come in true/inverted pairs: odd codes negate the even base.
    function automatic bit ref_pass(input logic [3:0] c, input logic [3:0] f);
        bit z, n, cy, v;
        bit base[7];
        z  = f[3];
        n  = f[2];
        cy = f[1];
        v  = f[0];
        if (c == 4'hE) return 1'b1;
        if (c == 4'hF) return 1'b0;
        base = '{z, cy, n, v, cy && !z, n == v, !z && (n == v)};
        return c[0] ? !base[c[3:1]] : base[c[3:1]];
    endfunction

    function automatic void model_step(input vec_t s);
        bit p;
        if (s.rst) begin
            m_flags = 4'b0000;
            m_rw = 0; m_mw = 0; m_pc = 0; m_ill = 0;
            m_cnt = 0;
        end else if (s.flush) begin
            m_rw = 0; m_mw = 0; m_pc = 0; m_ill = 0;
        end else if (!s.stall) begin
            p     = s.valid && ref_pass(s.cond, m_flags);
            m_rw  = s.rw && p;
            m_mw  = s.mw && p;
            m_pc  = s.pc && p;
            m_ill = s.valid && (s.cond == 4'hF);
            if (p && s.fw[1]) m_flags[3:2] = s.alu[3:2];
            if (p && s.fw[0]) m_flags[1:0] = s.alu[1:0];
            if (s.valid && !p && m_cnt < CNT_MAX) m_cnt++;
        end
    endfunction

    // Drive one E-stage cycle; returns cond_ex sampled before the edge.
    task automatic apply(input vec_t s, output logic ce);
        @(negedge clk);
        rst          = s.rst;
        stall        = s.stall;
        flush        = s.flush;
        valid_e      = s.valid;
        cond_e       = s.cond;
        flag_write_e = s.fw;
        alu_flags    = s.alu;
        reg_write_e  = s.rw;
        mem_write_e  = s.mw;
        pc_src_e     = s.pc;
        #1 ce = cond_ex;
        @(posedge clk);
        model_step(s);
        #1;
    endtask

    task automatic check_model(input string tag, input logic ce, input bit exp_ce);
        check({tag, ".cond_ex"}, 32'(ce), 32'(exp_ce));
        check({tag, ".flags"}, 32'(flags_q), 32'(m_flags));
        check({tag, ".reg_write_m"}, 32'(reg_write_m), 32'(m_rw));
        check({tag, ".mem_write_m"}, 32'(mem_write_m), 32'(m_mw));
        check({tag, ".pc_src_m"}, 32'(pc_src_m), 32'(m_pc));
        check({tag, ".illegal"}, 32'(illegal_cond_m), 32'(m_ill));
        check({tag, ".squash_cnt"}, 32'(squash_cnt), 32'(m_cnt));
    endtask

    vec_t tbl[24];

    initial begin
        vec_t s;
        logic ce;
        bit   exp_ce;

        rst = 1'b0; stall = 1'b0; flush = 1'b0; valid_e = 1'b0;
        cond_e = 4'h0; flag_write_e = 2'b00; alu_flags = 4'h0;
        reg_write_e = 1'b0; mem_write_e = 1'b0; pc_src_e = 1'b0;
        m_flags = 4'b0000; m_rw = 0; m_mw = 0; m_pc = 0; m_ill = 0; m_cnt = 0;

        //          rst   stl   fl    vld   cond   fw     alu      rw    mw    pc   | ce    flags    rw    mw    pc    ill   cnt
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'hE, 2'b11, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'hE, 2'b11, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'hE, 2'b10, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0111, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'hE, 2'b01, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'hB, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0110, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'hA, 2'b00, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'hE, 2'b10, 4'b1100, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1110, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'hC, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1110, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'hD, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1110, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'hE, 2'b11, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 2'b11, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'd3};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'hF, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'd4};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'hE, 2'b11, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'd4};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'hE, 2'b00, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 16'd4};
        tbl[16] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'hE, 2'b11, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 16'd4};
        tbl[17] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'hE, 2'b11, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 16'd4};
        tbl[18] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 2'b11, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 16'd4};
        tbl[19] = '{1'b0, 1'b1, 1'b1, 1'b1, 4'hE, 2'b11, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'd4};
        tbl[20] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'hF, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'd4};
        tbl[21] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'h2, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'd5};
        tbl[22] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'hE, 2'b11, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 16'd5};
        tbl[23] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'hE, 2'b11, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};

        for (int i = 0; i < 24; i++) begin
            apply(tbl[i], ce);
            check($sformatf("vec%0d.cond_ex", i), 32'(ce), 32'(tbl[i].e_ce));
            check($sformatf("vec%0d.flags", i), 32'(flags_q), 32'(tbl[i].e_flags));
            check($sformatf("vec%0d.reg_write_m", i), 32'(reg_write_m), 32'(tbl[i].e_rw));
            check($sformatf("vec%0d.mem_write_m", i), 32'(mem_write_m), 32'(tbl[i].e_mw));
            check($sformatf("vec%0d.pc_src_m", i), 32'(pc_src_m), 32'(tbl[i].e_pc));
            check($sformatf("vec%0d.illegal", i), 32'(illegal_cond_m), 32'(tbl[i].e_ill));
            check($sformatf("vec%0d.squash_cnt", i), 32'(squash_cnt), 32'(tbl[i].e_cnt));
        end

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            s.rst   = ($urandom_range(0, 99) == 0);
            s.stall = ($urandom_range(0, 7) == 0);
            s.flush = ($urandom_range(0, 9) == 0);
            s.valid = ($urandom_range(0, 3) != 0);
            s.cond  = 4'($urandom_range(0, 15));
            s.fw    = 2'($urandom_range(0, 3));
            s.alu   = 4'($urandom_range(0, 15));
            s.rw    = 1'($urandom_range(0, 1));
            s.mw    = 1'($urandom_range(0, 1));
            s.pc    = 1'($urandom_range(0, 1));
            exp_ce  = s.valid && ref_pass(s.cond, m_flags);
            apply(s, ce);
            check_model($sformatf("rnd%0d", i), ce, exp_ce);
        end

        // Saturation: reset, then drive NV instructions (always squashed)
        // until the counter is full, then one more.
        s = tbl[0];
        apply(s, ce);
        s.rst = 1'b0; s.valid = 1'b1; s.cond = 4'hF;
        for (int i = 0; i < CNT_MAX; i++) apply(s, ce);
        check("sat.full", 32'(squash_cnt), 32'(16'hFFFF));
        apply(s, ce);
        check("sat.hold", 32'(squash_cnt), 32'(16'hFFFF));
        check_model("sat", ce, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
